// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer that sits beside the EX stage.
// Radix-2 shift-add multiply and restoring divide run on magnitudes, and the sign is applied on completion.
module ex_muldiv_seq #(
  parameter int WORD_BITWIDTH = 32,
  parameter int CNT_BITWIDTH  = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               funct3,
  input  logic [WORD_BITWIDTH-1:0] operand_a,
  input  logic [WORD_BITWIDTH-1:0] operand_b,
  input  logic                     flush,
  output logic                     stall,
  output logic                     done,
  output logic [WORD_BITWIDTH-1:0] result
);

  localparam int W = WORD_BITWIDTH;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FINISH
  } state_t;

  state_t                  r_state;
  logic [CNT_BITWIDTH-1:0] r_cnt;
  logic [2:0]              r_funct3;
  logic                    r_neg;
  logic [W-1:0]            r_opnd;    // multiplicand or divisor magnitude
  logic [2*W-1:0]          r_prod;    // {acc, multiplier} or {rem, quo}
  logic [W-1:0]            r_result;
  logic                    r_done;

  // Operand decode for the op offered in IDLE
  logic         w_a_signed;
  logic         w_b_signed;
  logic         w_a_neg;
  logic         w_b_neg;
  logic [W-1:0] w_a_mag;
  logic [W-1:0] w_b_mag;
  logic         w_is_div;
  logic         w_is_rem;
  logic         w_neg_flag;
  logic         w_div_zero;
  logic         w_div_ovf;
  logic         w_special;
  logic [W-1:0] w_special_result;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (funct3)
      F3_MULH, F3_DIV, F3_REM: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      F3_MULHSU: w_a_signed = 1'b1;
      default: ;
    endcase
  end

  assign w_a_neg    = w_a_signed & operand_a[W-1];
  assign w_b_neg    = w_b_signed & operand_b[W-1];
  assign w_a_mag    = w_a_neg ? -operand_a : operand_a;
  assign w_b_mag    = w_b_neg ? -operand_b : operand_b;
  assign w_is_div   = funct3[2];
  assign w_is_rem   = funct3[2] & funct3[1];
  assign w_neg_flag = w_is_rem ? w_a_neg : (w_a_neg ^ w_b_neg);

  // The divide-by-zero and signed-overflow cases need no iterations.
  assign w_div_zero = w_is_div & (operand_b == '0);
  assign w_div_ovf  = w_is_div & ~funct3[0] & (operand_a == MOST_NEG) & (operand_b == '1);
  assign w_special  = w_div_zero | w_div_ovf;
  assign w_special_result = w_div_zero ? (w_is_rem ? operand_a : '1)
                                       : (w_is_rem ? '0 : MOST_NEG);

  // Single iteration step for both algorithms
  logic [W:0]     w_mul_sum;
  logic [2*W-1:0] w_mul_next;
  logic [2*W:0]   w_div_shift;
  logic [W:0]     w_trial;
  logic [2*W-1:0] w_div_next;
  logic [2*W-1:0] w_prod_next;

  assign w_mul_sum   = {1'b0, r_prod[2*W-1:W]} + (r_prod[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next  = {w_mul_sum, r_prod[W-1:1]};
  assign w_div_shift = {r_prod, 1'b0};
  assign w_trial     = w_div_shift[2*W:W] - {1'b0, r_opnd};
  assign w_div_next  = w_trial[W] ? w_div_shift[2*W-1:0]
                                  : {w_trial[W-1:0], w_div_shift[W-1:1], 1'b1};
  assign w_prod_next = r_funct3[2] ? w_div_next : w_mul_next;

  // Sign application and output select on the value the last iteration produces
  logic [2*W-1:0] w_prod_signed;
  logic [W-1:0]   w_quo_signed;
  logic [W-1:0]   w_rem_signed;
  logic [W-1:0]   w_final;

  assign w_prod_signed = r_neg ? -w_prod_next : w_prod_next;
  assign w_quo_signed  = r_neg ? -w_prod_next[W-1:0] : w_prod_next[W-1:0];
  assign w_rem_signed  = r_neg ? -w_prod_next[2*W-1:W] : w_prod_next[2*W-1:W];

  always_comb begin
    w_final = w_prod_signed[W-1:0];
    case (r_funct3)
      F3_MUL:                      w_final = w_prod_signed[W-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_final = w_prod_signed[2*W-1:W];
      F3_DIV, F3_DIVU:             w_final = w_quo_signed;
      F3_REM, F3_REMU:             w_final = w_rem_signed;
      default: ;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_neg    <= 1'b0;
      r_opnd   <= '0;
      r_prod   <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            r_funct3 <= funct3;
            r_neg    <= w_neg_flag;
            r_cnt    <= '0;
            if (w_is_div) begin
              r_opnd <= w_b_mag;
              r_prod <= {{W{1'b0}}, w_a_mag};
            end else begin
              r_opnd <= w_a_mag;
              r_prod <= {{W{1'b0}}, w_b_mag};
            end
            if (w_special) begin
              r_result <= w_special_result;
              r_done   <= 1'b1;
              r_state  <= S_FINISH;
            end else begin
              r_state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_prod <= w_prod_next;
            r_cnt  <= r_cnt + CNT_BITWIDTH'(1);
            // The result is registered as FINISH is entered so it is visible alongside done.
            if (r_cnt == CNT_BITWIDTH'(W - 1)) begin
              r_result <= w_final;
              r_done   <= 1'b1;
              r_state  <= S_FINISH;
            end
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign stall  = ((r_state == S_IDLE) & start & ~flush) | (r_state == S_CALC);
  assign done   = r_done;
  assign result = r_result;

endmodule
